// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the divided-clock sequencer.
package div_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned DEF_HALF_C = 5;

endpackage

// File: rtl/div_half_counter.sv
// Half-period counter: toggles q every max(half,1) enabled cycles and flags
// the edge that will raise or lower q so the controller can act on it.
module div_half_counter #(
  parameter int unsigned CW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          clear_i,
  input  logic [CW-1:0] half_i,
  output logic          q_o,
  output logic          rise_o,
  output logic          fall_o
);

  logic [CW-1:0] count_q, count_d, half_eff;
  logic          q_q, q_d, wrap;

  always_comb begin
    half_eff = (half_i == '0) ? CW'(1) : half_i;
    wrap     = en_i && (count_q == (half_eff - CW'(1)));
    count_d  = count_q;
    q_d      = q_q;
    if (clear_i) begin
      count_d = '0;
      q_d     = 1'b0;
    end else if (en_i) begin
      count_d = wrap ? '0 : (count_q + CW'(1));
      if (wrap) q_d = ~q_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      q_q     <= 1'b0;
    end else begin
      count_q <= count_d;
      q_q     <= q_d;
    end
  end

  assign q_o    = q_q;
  assign rise_o = wrap && !q_q;
  assign fall_o = wrap && q_q;

endmodule

// File: rtl/div_ctrl_sched.sv
// Divided-clock sequencer: IDLE | config writes active regs, waits for start
//                          RUN  | Q running, config is shadowed until Q falls
module div_ctrl_sched
  import div_ctrl_pkg::*;
#(
  parameter int unsigned CW       = 8,
  parameter int unsigned NW       = 8,
  parameter int unsigned DEF_HALF = DEF_HALF_C
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_half,
  input  logic [NW-1:0] cfg_burst,
  input  logic          start,
  input  logic          stop,
  output logic          Q,
  output logic          tick,
  output logic          busy,
  output logic          done
);

  state_e        state_q, state_d;
  logic [NW-1:0] period_cnt_q, period_cnt_d, pc_inc;
  logic [CW-1:0] half_act_q, half_act_d, half_sh_q, half_sh_d;
  logic [NW-1:0] burst_act_q, burst_act_d, burst_sh_q, burst_sh_d;
  logic          stop_req_q, stop_req_d, pending_q, pending_d;
  logic          done_q, done_d, tick_q, tick_d;
  logic          cnt_en, cnt_clear, rise, fall, xfer, end_run;

  assign cnt_en    = (state_q == RUN);
  assign cfg_ready = !((state_q == RUN) && pending_q);
  assign xfer      = cfg_valid && cfg_ready;

  div_half_counter #(.CW(CW)) u_half (
    .clk_i  (CLK),
    .rst_ni (RST),
    .en_i   (cnt_en),
    .clear_i(cnt_clear),
    .half_i (half_act_q),
    .q_o    (Q),
    .rise_o (rise),
    .fall_o (fall)
  );

  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    stop_req_d   = stop_req_q;
    pending_d    = pending_q;
    half_act_d   = half_act_q;
    burst_act_d  = burst_act_q;
    half_sh_d    = half_sh_q;
    burst_sh_d   = burst_sh_q;
    done_d       = 1'b0;
    tick_d       = 1'b0;
    cnt_clear    = 1'b0;
    pc_inc       = period_cnt_q + NW'(1);
    end_run      = stop_req_q || stop || ((burst_act_q != '0) && (pc_inc == burst_act_q));
    case (state_q)
      IDLE: begin
        if (xfer) begin
          half_act_d  = cfg_half;
          burst_act_d = cfg_burst;
          pending_d   = 1'b0;
        end
        if (start) begin
          state_d      = RUN;
          period_cnt_d = '0;
          stop_req_d   = 1'b0;
          cnt_clear    = 1'b1;
          // A config deferred by a stop governs the next run unless a fresh one arrives now.
          if (pending_q && !xfer) begin
            half_act_d  = half_sh_q;
            burst_act_d = burst_sh_q;
            pending_d   = 1'b0;
          end
        end
      end
      RUN: begin
        tick_d = rise;
        if (xfer) begin
          half_sh_d  = cfg_half;
          burst_sh_d = cfg_burst;
          pending_d  = 1'b1;
        end
        if (stop) stop_req_d = 1'b1;
        if (fall) begin
          if (end_run) begin
            state_d      = IDLE;
            period_cnt_d = pc_inc;
            stop_req_d   = 1'b0;
            done_d       = 1'b1;
            cnt_clear    = 1'b1;
          end else if (pending_q) begin
            half_act_d   = half_sh_q;
            burst_act_d  = burst_sh_q;
            pending_d    = 1'b0;
            period_cnt_d = '0;
          end else begin
            period_cnt_d = pc_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      period_cnt_q <= '0;
      stop_req_q   <= 1'b0;
      pending_q    <= 1'b0;
      half_act_q   <= CW'(DEF_HALF);
      burst_act_q  <= '0;
      half_sh_q    <= '0;
      burst_sh_q   <= '0;
      done_q       <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      stop_req_q   <= stop_req_d;
      pending_q    <= pending_d;
      half_act_q   <= half_act_d;
      burst_act_q  <= burst_act_d;
      half_sh_q    <= half_sh_d;
      burst_sh_q   <= burst_sh_d;
      done_q       <= done_d;
      tick_q       <= tick_d;
    end
  end

  assign tick = tick_q;
  assign busy = (state_q == RUN);
  assign done = done_q;

endmodule

// File: tb/tb_div_ctrl_sched.sv
// Directed bench for div_ctrl_sched; bit k of each capture vector is the value
// seen after the k-th rising edge following the stimulus.
module tb_div_ctrl_sched;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] cfg_half = 8'd0;
  logic [7:0] cfg_burst = 8'd0;
  logic       cfg_ready, Q, tick, busy, done;

  int checks = 0;
  int errors = 0;
  logic [31:0] cq, ct, cb, cd, cr, e;

  always #5 CLK = ~CLK;

  div_ctrl_sched #(.CW(8), .NW(8), .DEF_HALF(5)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_half (cfg_half),
    .cfg_burst(cfg_burst),
    .start    (start),
    .stop     (stop),
    .Q        (Q),
    .tick     (tick),
    .busy     (busy),
    .done     (done)
  );

  task automatic capture(input int n);
    cq = '0; ct = '0; cb = '0; cd = '0; cr = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      cq[k] = Q; ct[k] = tick; cb[k] = busy; cd[k] = done; cr[k] = cfg_ready;
      start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    #3;
    checks++; if (Q !== 1'b0) begin errors++; $display("FAIL reset_q: got %b expected 0", Q); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", tick); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", cfg_ready); end
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_default();
    start = 1'b1;
    capture(27);
    e = 27'b11_00000_11111_00000_11111_00000;
    checks++; if (cq !== e) begin errors++; $display("FAIL default_q: got %h expected %h", cq, e); end
    e = 27'b01_00000_00001_00000_00001_00000;
    checks++; if (ct !== e) begin errors++; $display("FAIL default_tick: got %h expected %h", ct, e); end
    e = 27'h7FF_FFFF;
    checks++; if (cb !== e) begin errors++; $display("FAIL default_busy: got %h expected %h", cb, e); end
    checks++; if (cr !== e) begin errors++; $display("FAIL default_ready: got %h expected %h", cr, e); end
    stop = 1'b1;
    capture(6);
    e = 6'b000111;
    checks++; if (cq !== e) begin errors++; $display("FAIL default_stop_q: got %h expected %h", cq, e); end
    checks++; if (cb !== e) begin errors++; $display("FAIL default_stop_busy: got %h expected %h", cb, e); end
    e = 6'b001000;
    checks++; if (cd !== e) begin errors++; $display("FAIL default_stop_done: got %h expected %h", cd, e); end
  endtask

  task automatic test_burst();
    cfg_valid = 1'b1; cfg_half = 8'd3; cfg_burst = 8'd2;
    capture(1);
    checks++; if (cb[0] !== 1'b0 || cr[0] !== 1'b1) begin errors++; $display("FAIL burst_cfg_idle: got busy %b ready %b expected busy 0 ready 1", cb[0], cr[0]); end
    start = 1'b1;
    capture(16);
    e = 16'b0000_1110_0011_1000;
    checks++; if (cq !== e) begin errors++; $display("FAIL burst_q: got %h expected %h", cq, e); end
    e = 16'b0000_0010_0000_1000;
    checks++; if (ct !== e) begin errors++; $display("FAIL burst_tick: got %h expected %h", ct, e); end
    e = 16'b0000_1111_1111_1111;
    checks++; if (cb !== e) begin errors++; $display("FAIL burst_busy: got %h expected %h", cb, e); end
    e = 16'b0001_0000_0000_0000;
    checks++; if (cd !== e) begin errors++; $display("FAIL burst_done: got %h expected %h", cd, e); end
  endtask

  task automatic test_ratio_change();
    cfg_valid = 1'b1; cfg_half = 8'd4; cfg_burst = 8'd0; start = 1'b1;
    capture(6);
    e = 6'b110000;
    checks++; if (cq !== e) begin errors++; $display("FAIL ratio_first_q: got %h expected %h", cq, e); end
    e = 6'b010000;
    checks++; if (ct !== e) begin errors++; $display("FAIL ratio_first_tick: got %h expected %h", ct, e); end
    cfg_valid = 1'b1; cfg_half = 8'd2;
    capture(9);
    e = 9'b100110011;
    checks++; if (cq !== e) begin errors++; $display("FAIL ratio_switch_q: got %h expected %h", cq, e); end
    e = 9'b111111100;
    checks++; if (cr !== e) begin errors++; $display("FAIL ratio_switch_ready: got %h expected %h", cr, e); end
    e = 9'b100010000;
    checks++; if (ct !== e) begin errors++; $display("FAIL ratio_switch_tick: got %h expected %h", ct, e); end
    stop = 1'b1;
    capture(3);
    e = 3'b001;
    checks++; if (cq !== e) begin errors++; $display("FAIL ratio_stop_q: got %h expected %h", cq, e); end
    checks++; if (cb !== e) begin errors++; $display("FAIL ratio_stop_busy: got %h expected %h", cb, e); end
    e = 3'b010;
    checks++; if (cd !== e) begin errors++; $display("FAIL ratio_stop_done: got %h expected %h", cd, e); end
  endtask

  task automatic test_half_zero();
    cfg_valid = 1'b1; cfg_half = 8'd0; cfg_burst = 8'd0;
    capture(1);
    start = 1'b1;
    capture(5);
    e = 5'b01010;
    checks++; if (cq !== e) begin errors++; $display("FAIL half0_q: got %h expected %h", cq, e); end
    checks++; if (ct !== e) begin errors++; $display("FAIL half0_tick: got %h expected %h", ct, e); end
    e = 5'b11111;
    checks++; if (cb !== e) begin errors++; $display("FAIL half0_busy: got %h expected %h", cb, e); end
    stop = 1'b1;
    capture(3);
    e = 3'b001;
    checks++; if (cq !== e) begin errors++; $display("FAIL half0_stop_q: got %h expected %h", cq, e); end
    checks++; if (cb !== e) begin errors++; $display("FAIL half0_stop_busy: got %h expected %h", cb, e); end
    e = 3'b010;
    checks++; if (cd !== e) begin errors++; $display("FAIL half0_stop_done: got %h expected %h", cd, e); end
  endtask

  task automatic test_stop_pending_then_reset();
    cfg_valid = 1'b1; cfg_half = 8'd4; cfg_burst = 8'd0; start = 1'b1;
    capture(6);
    e = 6'b110000;
    checks++; if (cq !== e) begin errors++; $display("FAIL sp_first_q: got %h expected %h", cq, e); end
    cfg_valid = 1'b1; cfg_half = 8'd2; stop = 1'b1;
    capture(4);
    e = 4'b0011;
    checks++; if (cq !== e) begin errors++; $display("FAIL sp_stop_q: got %h expected %h", cq, e); end
    checks++; if (cb !== e) begin errors++; $display("FAIL sp_stop_busy: got %h expected %h", cb, e); end
    e = 4'b0100;
    checks++; if (cd !== e) begin errors++; $display("FAIL sp_stop_done: got %h expected %h", cd, e); end
    e = 4'b1100;
    checks++; if (cr !== e) begin errors++; $display("FAIL sp_stop_ready: got %h expected %h", cr, e); end
    start = 1'b1;
    capture(6);
    e = 6'b001100;
    checks++; if (cq !== e) begin errors++; $display("FAIL sp_restart_q: got %h expected %h", cq, e); end
    e = 6'b000100;
    checks++; if (ct !== e) begin errors++; $display("FAIL sp_restart_tick: got %h expected %h", ct, e); end
    e = 6'b111111;
    checks++; if (cr !== e) begin errors++; $display("FAIL sp_restart_ready: got %h expected %h", cr, e); end
    cfg_valid = 1'b1; cfg_half = 8'd7; cfg_burst = 8'd0;
    capture(1);
    checks++; if (cq[0] !== 1'b1 || ct[0] !== 1'b1 || cr[0] !== 1'b0) begin
      errors++; $display("FAIL rst_pre: got q %b tick %b ready %b expected q 1 tick 1 ready 0", cq[0], ct[0], cr[0]);
    end
    #2 RST = 1'b0;
    #1;
    checks++; if (Q !== 1'b0) begin errors++; $display("FAIL rst_async_q: got %b expected 0", Q); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b expected 0", busy); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL rst_async_tick: got %b expected 0", tick); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_async_ready: got %b expected 1", cfg_ready); end
    @(negedge CLK);
    RST = 1'b1;
    capture(2);
    checks++; if (cd !== 32'd0 || cb !== 32'd0) begin errors++; $display("FAIL rst_no_done: got done %h busy %h expected 0 0", cd, cb); end
    start = 1'b1;
    capture(7);
    e = 7'b1100000;
    checks++; if (cq !== e) begin errors++; $display("FAIL rst_default_half_q: got %h expected %h", cq, e); end
    e = 7'b0100000;
    checks++; if (ct !== e) begin errors++; $display("FAIL rst_default_half_tick: got %h expected %h", ct, e); end
  endtask

  initial begin
    test_reset();
    test_default();
    test_burst();
    test_ratio_change();
    test_half_zero();
    test_stop_pending_then_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
